mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single data-memory port between instruction fetch (IFU) and load/store (LSU).
//   Uses round-robin arbitration with one outstanding transaction at a time.
//   For LSU loads, zero- or sign-extends read data by len/load_unsign; IFU fetches are always 4-byte.
//   Sits between IFU/LSU and the memory model (DPI mem_read/mem_write wrapper).
// PARAMETERS
//   AW  32  address width
//   DW  32  data width (fixed 32; len encodings assume it)
// PORTS
//   clk            in   1   clock, all state on rising edge
//   rst_n          in   1   asynchronous, active-low reset
//   ifu_valid      in   1   IFU fetch request
//   ifu_ready      out  1   IFU request accepted this cycle
//   ifu_addr       in   AW  fetch address (pc)
//   ifu_rvalid     out  1   fetch response, 1-cycle pulse
//   ifu_rdata      out  DW  instruction word
//   lsu_valid      in   1   LSU request
//   lsu_ready      out  1   LSU request accepted this cycle
//   lsu_addr       in   AW  data address
//   lsu_wen        in   1   1=store, 0=load
//   lsu_wdata      in   DW  store data
//   lsu_len        in   3   bytes: 1,2,4; any other value is illegal
//   lsu_unsign     in   1   load zero-extend (1) / sign-extend (0)
//   lsu_rvalid     out  1   load data / store ack, 1-cycle pulse
//   lsu_rdata      out  DW  extended load data; 0 for stores
//   lsu_err        out  1   qualifies lsu_rvalid: illegal len
//   mem_req_valid  out  1   request to memory
//   mem_req_ready  in   1   memory accepts request
//   mem_addr       out  AW  registered address
//   mem_wen        out  1   write enable
//   mem_wdata      out  DW  write data
//   mem_len        out  3   byte count
//   mem_resp_valid in   1   memory response (reads and writes)
//   mem_resp_data  in   DW  raw read data, bytes in [len*8-1:0]
// BEHAVIOUR
//   Reset: state=IDLE, last_grant=LSU (IFU wins the first tie); all outputs and regs 0.
//   FSM: IDLE -> REQ -> WAIT -> RESP -> IDLE.
//   IDLE:
//     ifu_ready/lsu_ready are combinational and only ever high in IDLE; at most one is high.
//     Single requester: grant it. Both: grant the requester != last_grant.
//     On grant (valid&ready): latch addr/wen/wdata/len/unsign and owner; last_grant<=owner.
//     IFU requests latch as len=4, wen=0.
//     Next state is REQ.
//     LSU with illegal len: no memory access; go to RESP with err=1.
//   REQ:
//     mem_req_valid=1, fields stable until mem_req_ready.
//     On handshake -> WAIT. mem_req_valid must not drop before ready.
//   WAIT:
//     On mem_resp_valid, capture mem_resp_data -> RESP.
//     mem_resp_valid in the same cycle as the REQ handshake is ignored; memory responds at least one cycle later.
//   RESP:
//     Owner's rvalid=1 for exactly one cycle; then IDLE.
//     No backpressure on responses.
//     A new request can be granted in the cycle after RESP (IDLE).
//   Extension (LSU load):
//     len1: unsign ? {24'b0,d[7:0]} : {{24{d[7]}},d[7:0]}
//     len2: unsign ? {16'b0,d[15:0]} : {{16{d[15]}},d[15:0]}
//     len4: d
//     Upper raw bits ignored. Stores: lsu_rdata=0.
//   ifu_rdata = raw 32-bit word. rdata holds its value outside rvalid.
//   Min latency: grant at T, mem_req_valid T+1, resp T+2 earliest, rvalid T+3.
//   mem_resp_valid outside WAIT is ignored; no error flagged.
//   Async reset mid-transaction: immediate IDLE, no rvalid; any in-flight response is dropped.
//   No address alignment checks; misaligned accesses pass through.
// TESTING
//   1 IFU only, addr 0x80000000, mem returns 0x00000413 after 1 wait
//     -> ifu_rvalid at T+4, ifu_rdata=0x00000413.
//   2 IFU+LSU valid in same IDLE cycle after reset -> IFU granted first, then LSU.
//     Repeat with both held high -> strict alternation.
//   3 LSU load len=1 unsign=0, mem data 0x000000F0 -> lsu_rdata=0xFFFFFFF0.
//     unsign=1 -> 0x000000F0. len=2 of 0x8001 signed -> 0xFFFF8001.
//   4 LSU store len=4 addr 0x80001000 data 0xDEADBEEF
//     -> mem_wen=1, mem_len=4 held through 3 stall cycles of !mem_req_ready; lsu_rvalid, lsu_rdata=0.
//   5 LSU len=3 -> no mem_req_valid; lsu_rvalid with lsu_err=1 two cycles after grant.
//   6 rst_n low while in WAIT, late mem_resp_valid after release
//     -> no rvalid, FSM IDLE; next IFU request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shared data-memory port arbiter.
// The instruction-fetch unit (IFU) and the load/store unit (LSU) share one memory port.
// Requests are granted round-robin, and only one transaction is outstanding at a time.
// Load data going back to the LSU is zero- or sign-extended to the access size.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ifu_valid,
  output logic          ifu_ready,
  input  logic [AW-1:0] ifu_addr,
  output logic          ifu_rvalid,
  output logic [DW-1:0] ifu_rdata,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [AW-1:0] lsu_addr,
  input  logic          lsu_wen,
  input  logic [DW-1:0] lsu_wdata,
  input  logic [2:0]    lsu_len,
  input  logic          lsu_unsign,
  output logic          lsu_rvalid,
  output logic [DW-1:0] lsu_rdata,
  output logic          lsu_err,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wen,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_len,
  input  logic          mem_resp_valid,
  input  logic [DW-1:0] mem_resp_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       owner;
  logic       last_grant;
  logic       unsign_q;
  logic       err_q;
  logic       lsu_len_ok;
  logic       grant_any;

  // Size the raw memory word to the access length and extend it; upper raw bits are discarded.
  function automatic logic [DW-1:0] extend_load(input logic [DW-1:0] d,
                                                input logic [2:0]    len,
                                                input logic          uns);
    logic signed [DW-1:0] ext;
    case (len)
      3'd1:    ext = uns ? {24'b0, d[7:0]}  : {{24{d[7]}},  d[7:0]};
      3'd2:    ext = uns ? {16'b0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: ext = d;
    endcase
    return ext;
  endfunction

  // Round-robin grant, only while idle; on a tie the requester that was not served last wins.
  always_comb begin
    ifu_ready  = (state == S_IDLE) && ifu_valid && (!lsu_valid || (last_grant == OWN_LSU));
    lsu_ready  = (state == S_IDLE) && lsu_valid && (!ifu_valid || (last_grant == OWN_IFU));
    grant_any  = ifu_ready || lsu_ready;
    lsu_len_ok = (lsu_len == 3'd1) || (lsu_len == 3'd2) || (lsu_len == 3'd4);
  end

  // Handshake and response strobes, decoded from the FSM state.
  // An errored LSU access never reaches memory.
  always_comb begin
    mem_req_valid = (state == S_REQ) && !err_q;
    ifu_rvalid    = (state == S_RESP) && (owner == OWN_IFU);
    lsu_rvalid    = (state == S_RESP) && (owner == OWN_LSU);
    lsu_err       = lsu_rvalid && err_q;
  end

  // Next state.
  // An illegal-length LSU access still passes through REQ, with no memory request.
  // That keeps the error response two cycles after the grant.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_any) state_nxt = S_REQ;
      S_REQ: begin
        if (err_q)              state_nxt = S_RESP;
        else if (mem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT:  if (mem_resp_valid) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  // An asynchronous reset drops any transaction that is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Latch the granted request and record its owner for the round-robin decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= OWN_IFU;
      last_grant <= OWN_LSU;
      mem_addr   <= '0;
      mem_wen    <= 1'b0;
      mem_wdata  <= '0;
      mem_len    <= 3'd0;
      unsign_q   <= 1'b0;
      err_q      <= 1'b0;
    end else if (ifu_ready) begin
      owner      <= OWN_IFU;
      last_grant <= OWN_IFU;
      mem_addr   <= ifu_addr;
      mem_wen    <= 1'b0;
      mem_wdata  <= '0;
      mem_len    <= 3'd4;
      unsign_q   <= 1'b0;
      err_q      <= 1'b0;
    end else if (lsu_ready) begin
      owner      <= OWN_LSU;
      last_grant <= OWN_LSU;
      mem_addr   <= lsu_addr;
      mem_wen    <= lsu_wen;
      mem_wdata  <= lsu_wdata;
      mem_len    <= lsu_len;
      unsign_q   <= lsu_unsign;
      err_q      <= !lsu_len_ok;
    end
  end

  // Capture response data for the owner.
  // Stores and errored accesses return zero to the LSU.
  // The data is held between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifu_rdata <= '0;
      lsu_rdata <= '0;
    end else if ((state == S_WAIT) && mem_resp_valid) begin
      if (owner == OWN_IFU) ifu_rdata <= mem_resp_data;
      else if (mem_wen)     lsu_rdata <= '0;
      else                  lsu_rdata <= extend_load(mem_resp_data, mem_len, unsign_q);
    end else if ((state == S_REQ) && err_q) begin
      lsu_rdata <= '0;
    end
  end

endmodule
